// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule blocks: widths, FSM encoding,
// round-constant lookup and GF(2^8) helpers.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int KEY_W  = 128;
  localparam int RND_W  = 4;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [KEY_W-1:0]  key_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  // Round constant used when stepping from round rnd back to round rnd-1.
  function automatic byte_t rcon(input logic [RND_W-1:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t acc;
    byte_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < BYTE_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_key_expand_if.sv
// Handshake bundle between the inverse key expander and its consumer.
// The master side starts a schedule and accepts round keys.
interface aes_inv_key_expand_if
  import aes_pkg::*;
#(
  parameter int IDX_W = 4
) ();

  logic             start;
  key_t             key_in;
  key_t             rk_out;
  logic [IDX_W-1:0] rk_idx;
  logic             rk_valid;
  logic             rk_ready;
  logic             busy;
  logic             done;

  modport master (
    output start, key_in, rk_ready,
    input  rk_out, rk_idx, rk_valid, busy, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output rk_out, rk_idx, rk_valid, busy, done
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box: multiplicative inverse in GF(2^8)
// followed by the affine transform.
module aes_sbox
  import aes_pkg::*;
(
  input  byte_t in_byte,
  output byte_t out_byte
);

  byte_t sq;
  byte_t inv;

  // inv = x^254 = x^(2+4+...+128), which maps 0 to 0 as the S-box requires.
  always_comb begin
    // NOTE: every variable gets a value before any branch or loop, so no latch can be inferred.
    sq  = in_byte;
    inv = 8'h01;
    for (int i = 1; i < BYTE_W; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    out_byte = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;
  end

endmodule

// File: rtl/aes_inv_key_expand.sv
// Inverse AES-128 key schedule: given the round-10 key, emits round keys
// 10 down to 0, one per ready/valid handshake, holding only the current key.
module aes_inv_key_expand
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NR,
  parameter int IDX_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_inv_key_expand_if.slave  bus
);

  state_e           state_q, state_d;
  key_t             key_q, key_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  word_t w0, w1, w2, w3;
  word_t p0, p1, p2, p3;
  word_t sub_in, sub_out;
  key_t  prev_key;
  logic  hs;

  assign hs = valid_q & bus.rk_ready;

  // Backward step: the last three words of round r-1 fall out of XORs of
  // adjacent words of round r; word 0 needs SubWord(RotWord()) of the new word 3.
  assign {w0, w1, w2, w3} = key_q;
  assign p3     = w3 ^ w2;
  assign p2     = w2 ^ w1;
  assign p1     = w1 ^ w0;
  assign sub_in = rot_word(p3);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (sub_in[g*BYTE_W +: BYTE_W]),
      .out_byte (sub_out[g*BYTE_W +: BYTE_W])
    );
  end

  assign p0       = w0 ^ sub_out ^ {rcon(RND_W'(idx_q)), 24'h0};
  assign prev_key = {p0, p1, p2, p3};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          key_d   = bus.key_in;
          idx_d   = IDX_W'(NUM_ROUNDS);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        // START is not looked at here, so KEY_IN cannot disturb a run in progress.
        if (hs) begin
          if (idx_q != '0) begin
            key_d = prev_key;
            idx_d = idx_q - 1'b1;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the key register is reset too, because RK_OUT must read zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.rk_out   = key_q;
  assign bus.rk_idx   = idx_q;
  assign bus.rk_valid = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  a_valid_while_busy : assert property (@(posedge clk) disable iff (!rst_n)
    busy_q |-> valid_q);

  a_hold_when_stalled : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_EMIT && !bus.rk_ready) |=> ($stable(key_q) && $stable(idx_q)));

  a_done_one_cycle : assert property (@(posedge clk) disable iff (!rst_n)
    done_q |=> !done_q);

  a_idx_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    idx_q <= IDX_W'(NUM_ROUNDS));

endmodule

// File: tb/tb_aes_inv_key_expand.sv
// Directed bench for the inverse AES-128 key expander: FIPS-197 vectors,
// backpressure, ignored START, mid-run reset, round trips and START-on-DONE.
module tb_aes_inv_key_expand;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_inv_key_expand_if #(.IDX_W(4)) bus ();

  aes_inv_key_expand #(.NUM_ROUNDS(10), .IDX_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] fips_a1  [0:10];
  logic [127:0] exp_keys [0:10];
  logic [7:0]   sbox_tab [0:255];
  logic [7:0]   rcon_tb  [1:10];
  logic [127:0] last_key;
  int           last_cycles;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] r;
    x = a;
    y = b;
    r = 8'h00;
    while (y != 8'h00) begin
      if (y[0]) r = r ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return r;
  endfunction

  // S-box from a brute-force inverse search plus the bitwise affine map.
  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] rc;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = b;
    end
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      rcon_tb[r] = rc;
      rc = tb_mul(rc, 8'h02);
    end
  endtask

  // Forward key expansion; fills exp_keys[0..10].
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon_tb[i/4];
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at a negedge with the DUT idle; returns one negedge after the load.
  task automatic start_key(input logic [127:0] k);
    bus.start  = 1'b1;
    bus.key_in = k;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    check("start valid", bus.rk_valid, 1);
    check("start idx", bus.rk_idx, 10);
    check("start busy", bus.busy, 1);
    check("start key", bus.rk_out, k);
  endtask

  // Accepts keys from_idx down to to_idx with READY high pct% of cycles.
  task automatic collect(input int from_idx, input int to_idx, input int pct);
    int   e;
    int   cyc;
    logic rdy;
    e   = from_idx;
    cyc = 0;
    while (e >= to_idx && cyc < 400) begin
      rdy = ($urandom_range(99) < pct);
      bus.rk_ready = rdy;
      if (bus.rk_valid && rdy) begin
        check($sformatf("idx at %0d", e), bus.rk_idx, e);
        check($sformatf("key at %0d", e), bus.rk_out, exp_keys[e]);
        last_key = bus.rk_out;
        e--;
      end
      @(negedge clk);
      cyc++;
    end
    bus.rk_ready = 1'b0;
    check("collect count", e, to_idx - 1);
    last_cycles = cyc;
  endtask

  task automatic check_done_cycle();
    check("done high", bus.done, 1);
    check("done busy", bus.busy, 0);
    check("done valid", bus.rk_valid, 0);
  endtask

  task automatic finish_done();
    check_done_cycle();
    @(negedge clk);
    check("done pulse width", bus.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k;
    bus.start    = 1'b0;
    bus.key_in   = '0;
    bus.rk_ready = 1'b0;

    fips_a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    build_tables();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset rk_out", bus.rk_out, 0);
    check("reset rk_idx", bus.rk_idx, 0);
    check("reset valid", bus.rk_valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 A.1 with READY held: 11 keys in 11 cycles
    for (int r = 0; r <= 10; r++) exp_keys[r] = fips_a1[r];
    start_key(fips_a1[10]);
    collect(10, 0, 100);
    check("a1 cycles", last_cycles, 11);
    finish_done();
    @(negedge clk);
    check("idle no done", bus.done, 0);

    // Backpressure at idx 9, then random READY
    start_key(fips_a1[10]);
    collect(10, 10, 100);
    for (int s = 0; s < 3; s++) begin
      check("stall idx", bus.rk_idx, 9);
      check("stall key", bus.rk_out, fips_a1[9]);
      check("stall valid", bus.rk_valid, 1);
      @(negedge clk);
    end
    collect(9, 0, 50);
    finish_done();

    // START while busy is ignored
    start_key(fips_a1[10]);
    collect(10, 9, 100);
    bus.start  = 1'b1;
    bus.key_in = 128'h0123456789abcdeffedcba9876543210;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy start idx", bus.rk_idx, 8);
    check("busy start key", bus.rk_out, fips_a1[8]);
    check("busy start busy", bus.busy, 1);
    collect(8, 0, 100);
    finish_done();

    // Asynchronous reset at idx 5, then restart
    start_key(fips_a1[10]);
    collect(10, 6, 100);
    check("pre-reset idx", bus.rk_idx, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async rst rk_out", bus.rk_out, 0);
    check("async rst rk_idx", bus.rk_idx, 0);
    check("async rst valid", bus.rk_valid, 0);
    check("async rst busy", bus.busy, 0);
    check("async rst done", bus.done, 0);
    @(negedge clk);
    check("in rst done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst done", bus.done, 0);
    start_key(fips_a1[10]);
    collect(10, 0, 70);
    finish_done();

    // Round trips from random cipher keys
    for (int t = 0; t < 3; t++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(k);
      start_key(exp_keys[10]);
      collect(10, 0, 60);
      check($sformatf("rt%0d cipher key", t), last_key, k);
      finish_done();
    end

    // START in the DONE cycle is accepted (FIPS-197 C.1 key follows)
    for (int r = 0; r <= 10; r++) exp_keys[r] = fips_a1[r];
    start_key(fips_a1[10]);
    collect(10, 0, 100);
    check_done_cycle();
    bus.start  = 1'b1;
    bus.key_in = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    @(negedge clk);
    bus.start = 1'b0;
    check("done-start valid", bus.rk_valid, 1);
    check("done-start idx", bus.rk_idx, 10);
    check("done-start key", bus.rk_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    expand(128'h000102030405060708090a0b0c0d0e0f);
    collect(10, 0, 100);
    check("c1 cipher key", last_key, 128'h000102030405060708090a0b0c0d0e0f);
    finish_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
